// File: rtl/status_reg_unit_pkg.sv
// Flag definitions shared by the status register, condition evaluation and the ALU.
package status_reg_unit_pkg;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef logic [3:0] nzcv_t;

   localparam nzcv_t NZCV_RESET = 4'b0000;

endpackage

// File: rtl/flag_save_stack.sv
// LIFO of saved NZCV flag sets used for nested exception entry/return.
module flag_save_stack
   import status_reg_unit_pkg::*;
#(
   parameter int STACK_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  logic        pop,
   input  nzcv_t       data_in,
   output nzcv_t       data_out,
   output logic [2:0]  depth,
   output logic        full,
   output logic        empty
);

   nzcv_t entries [STACK_DEPTH];

   assign full  = (depth == 3'(STACK_DEPTH));
   assign empty = (depth == 3'd0);

   // Push writes the slot just above the current top; push wins over pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entries <= '{default: NZCV_RESET};
         depth   <= 3'd0;
      end else begin
         for (int i = 0; i < STACK_DEPTH; i++) begin
            if (push && !full && depth == 3'(i)) begin
               entries[i] <= data_in;
            end
         end
         if (push && !full) begin
            depth <= depth + 3'd1;
         end else if (pop && !empty) begin
            depth <= depth - 3'd1;
         end
      end
   end

   always_comb begin
      data_out = NZCV_RESET;
      for (int i = 0; i < STACK_DEPTH; i++) begin
         if (depth == 3'(i + 1)) begin
            data_out = entries[i];
         end
      end
   end

endmodule

// File: rtl/status_reg_unit.sv
// NZCV status register with ALU/MSR update, exception save stack and sticky error.
// Define SR_BYPASS_EN to forward the next-edge SR value on SR_fwd.
module status_reg_unit
   import status_reg_unit_pkg::*;
#(
   parameter int STACK_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  alu_flags,
   input  logic        s_bit,
   input  logic        upd_valid,
   input  logic        cond_pass,
   input  logic        msr_we,
   input  logic [3:0]  msr_data,
   input  logic        exc_entry,
   input  logic        exc_return,
   input  logic        stall,
   input  logic        flush,
   output logic [3:0]  SR,
   output logic [3:0]  SR_fwd,
   output logic [2:0]  depth,
   output logic        flags_changed,
   output logic        stack_err
);

   nzcv_t sr_next;
   nzcv_t stack_top;
   logic  stack_full;
   logic  stack_empty;
   logic  do_entry;
   logic  do_return;
   logic  err_next;

   // Entry beats return; flush only masks the ALU and MSR sources.
   assign do_entry  = exc_entry & ~stall;
   assign do_return = exc_return & ~exc_entry & ~stall;
   assign err_next  = (do_entry & stack_full) | (do_return & stack_empty);

   flag_save_stack #(
      .STACK_DEPTH(STACK_DEPTH)
   ) u_stack (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (do_entry),
      .pop      (do_return),
      .data_in  (SR),
      .data_out (stack_top),
      .depth    (depth),
      .full     (stack_full),
      .empty    (stack_empty)
   );

   always_comb begin
      sr_next = SR;
      if (stall || exc_entry) begin
         sr_next = SR;
      end else if (exc_return) begin
         if (!stack_empty) begin
            sr_next = stack_top;
         end
      end else if (flush) begin
         sr_next = SR;
      end else if (msr_we) begin
         sr_next = msr_data;
      end else if (upd_valid && s_bit && cond_pass) begin
         sr_next = alu_flags;
      end
   end

   // A stalled cycle freezes everything, including the change pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         SR            <= NZCV_RESET;
         flags_changed <= 1'b0;
         stack_err     <= 1'b0;
      end else if (!stall) begin
         SR            <= sr_next;
         flags_changed <= (sr_next != SR);
         if (err_next) begin
            stack_err <= 1'b1;
         end
      end
   end

`ifdef SR_BYPASS_EN
   assign SR_fwd = sr_next;
`else
   assign SR_fwd = SR;
`endif

endmodule

// File: tb/tb_status_reg_unit.sv
// Scoreboard bench for status_reg_unit: directed cases plus randomized traffic vs a queue-based model.
module tb_status_reg_unit;

   localparam int DEPTH = 2;

   typedef struct packed {
      logic [3:0] alu;
      logic       s;
      logic       upd;
      logic       cond;
      logic       msr;
      logic [3:0] msr_d;
      logic       entry;
      logic       ret;
      logic       stall;
      logic       flush;
   } stim_t;

   typedef struct {
      logic [3:0] sr;
      logic [3:0] fwd;
      logic [2:0] depth;
      logic       fc;
      logic       err;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] alu_flags;
   logic       s_bit, upd_valid, cond_pass, msr_we;
   logic [3:0] msr_data;
   logic       exc_entry, exc_return, stall, flush;
   logic [3:0] SR, SR_fwd;
   logic [2:0] depth;
   logic       flags_changed, stack_err;

   int total = 0;
   int bad   = 0;

   exp_t       sb [$];
   logic [3:0] m_saved [$];
   logic [3:0] m_sr;
   logic       m_fc, m_err;
   stim_t      cur;

   always #5 clk = ~clk;

   status_reg_unit #(.STACK_DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .alu_flags     (alu_flags),
      .s_bit         (s_bit),
      .upd_valid     (upd_valid),
      .cond_pass     (cond_pass),
      .msr_we        (msr_we),
      .msr_data      (msr_data),
      .exc_entry     (exc_entry),
      .exc_return    (exc_return),
      .stall         (stall),
      .flush         (flush),
      .SR            (SR),
      .SR_fwd        (SR_fwd),
      .depth         (depth),
      .flags_changed (flags_changed),
      .stack_err     (stack_err)
   );

   task automatic checkOutput(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      return s;
   endfunction

   // SR value after the coming edge, from the priority rules.
   function automatic logic [3:0] predictSr(input stim_t s);
      if (s.stall || s.entry) return m_sr;
      if (s.ret) return (m_saved.size() > 0) ? m_saved[m_saved.size() - 1] : m_sr;
      if (s.flush) return m_sr;
      if (s.msr) return s.msr_d;
      if (s.upd && s.s && s.cond) return s.alu;
      return m_sr;
   endfunction

   task automatic modelStep(input stim_t s);
      logic [3:0] nsr;
      if (s.stall) return;
      nsr = predictSr(s);
      if (s.entry) begin
         if (m_saved.size() < DEPTH) m_saved.push_back(m_sr);
         else m_err = 1'b1;
      end else if (s.ret) begin
         if (m_saved.size() > 0) void'(m_saved.pop_back());
         else m_err = 1'b1;
      end
      m_fc = (nsr != m_sr);
      m_sr = nsr;
   endtask

   task automatic modelReset();
      m_saved.delete();
      m_sr  = 4'b0000;
      m_fc  = 1'b0;
      m_err = 1'b0;
   endtask

   task automatic drive(input stim_t s);
      alu_flags  = s.alu;
      s_bit      = s.s;
      upd_valid  = s.upd;
      cond_pass  = s.cond;
      msr_we     = s.msr;
      msr_data   = s.msr_d;
      exc_entry  = s.entry;
      exc_return = s.ret;
      stall      = s.stall;
      flush      = s.flush;
   endtask

   // Commit the previous cycle's inputs in the model, queue the expectation, then drive s.
   task automatic applyStimulus(input stim_t s);
      exp_t e;
      @(posedge clk);
      if (rst_n) modelStep(cur);
      cur = s;
      e.sr    = m_sr;
      e.depth = 3'(m_saved.size());
      e.fc    = m_fc;
      e.err   = m_err;
`ifdef SR_BYPASS_EN
      e.fwd   = predictSr(cur);
`else
      e.fwd   = m_sr;
`endif
      sb.push_back(e);
      #1 drive(cur);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checkOutput("sr", SR, e.sr);
         checkOutput("sr_fwd", SR_fwd, e.fwd);
         checkOutput("depth", depth, e.depth);
         checkOutput("flags_changed", flags_changed, e.fc);
         checkOutput("stack_err", stack_err, e.err);
      end
   end

   function automatic stim_t aluUpd(input logic [3:0] f, input logic s, input logic c, input logic fl);
      stim_t x;
      x = idle();
      x.upd = 1'b1; x.s = s; x.cond = c; x.alu = f; x.flush = fl;
      return x;
   endfunction

   function automatic stim_t msrW(input logic [3:0] d);
      stim_t x;
      x = idle();
      x.msr = 1'b1; x.msr_d = d;
      return x;
   endfunction

   function automatic stim_t entryS();
      stim_t x;
      x = idle();
      x.entry = 1'b1;
      return x;
   endfunction

   function automatic stim_t retS();
      stim_t x;
      x = idle();
      x.ret = 1'b1;
      return x;
   endfunction

   function automatic stim_t randStim();
      stim_t x;
      x.alu   = 4'($urandom_range(0, 15));
      x.s     = ($urandom_range(0, 99) < 70);
      x.upd   = ($urandom_range(0, 99) < 70);
      x.cond  = ($urandom_range(0, 99) < 70);
      x.msr   = ($urandom_range(0, 99) < 20);
      x.msr_d = 4'($urandom_range(0, 15));
      x.entry = ($urandom_range(0, 99) < 12);
      x.ret   = ($urandom_range(0, 99) < 12);
      x.stall = ($urandom_range(0, 99) < 15);
      x.flush = ($urandom_range(0, 99) < 15);
      return x;
   endfunction

   initial begin
      stim_t s;
      rst_n = 1'b0;
      cur = idle();
      drive(cur);
      modelReset();
      #7;
      checkOutput("reset_sr", SR, 4'b0000);
      checkOutput("reset_depth", depth, 3'd0);
      checkOutput("reset_fc", flags_changed, 1'b0);
      checkOutput("reset_err", stack_err, 1'b0);
      #5 rst_n = 1'b1;

      // First-edge ALU update, then non-updating variants of the same.
      applyStimulus(aluUpd(4'b0100, 1'b1, 1'b1, 1'b0));
      applyStimulus(idle());
      applyStimulus(aluUpd(4'b1111, 1'b1, 1'b0, 1'b0));
      applyStimulus(aluUpd(4'b1111, 1'b0, 1'b1, 1'b0));
      applyStimulus(aluUpd(4'b1111, 1'b1, 1'b1, 1'b1));
      applyStimulus(aluUpd(4'b0100, 1'b1, 1'b1, 1'b0));

      // Save, overwrite, restore.
      applyStimulus(msrW(4'b1001));
      applyStimulus(entryS());
      applyStimulus(msrW(4'b0010));
      applyStimulus(retS());
      applyStimulus(idle());

      // Overflow, LIFO restore, underflow.
      applyStimulus(msrW(4'b0001));
      applyStimulus(entryS());
      applyStimulus(msrW(4'b0110));
      applyStimulus(entryS());
      applyStimulus(msrW(4'b1100));
      applyStimulus(entryS());
      applyStimulus(retS());
      applyStimulus(retS());
      applyStimulus(retS());

      // Stall with competing writes, simultaneous entry/return, flush with entry.
      s = msrW(4'b1010); s.entry = 1'b1; s.stall = 1'b1;
      applyStimulus(s);
      s = entryS(); s.ret = 1'b1;
      applyStimulus(s);
      s = entryS(); s.flush = 1'b1; s.msr = 1'b1; s.msr_d = 4'b0011;
      applyStimulus(s);
      applyStimulus(aluUpd(4'b1000, 1'b1, 1'b1, 1'b0));
      applyStimulus(idle());

      for (int i = 0; i < 600; i++) begin
         applyStimulus(randStim());
      end

      // Asynchronous reset while an entry is saved.
      applyStimulus(retS());
      applyStimulus(retS());
      applyStimulus(entryS());
      applyStimulus(idle());
      @(negedge clk);
      #1 rst_n = 1'b0;
      cur = idle();
      drive(cur);
      #1;
      checkOutput("async_sr", SR, 4'b0000);
      checkOutput("async_depth", depth, 3'd0);
      checkOutput("async_err", stack_err, 1'b0);
      modelReset();
      #1 rst_n = 1'b1;
      applyStimulus(retS());
      applyStimulus(msrW(4'b0111));
      applyStimulus(idle());
      repeat (3) @(posedge clk);
      checkOutput("scoreboard_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/status_reg_unit.md
STATUS_REG_UNIT -- requirements
Module: status_reg_unit

Interface
REQ-001 The module SHALL take parameter STACK_DEPTH, default 2, the number of saved-flag entries for nested exceptions (legal range 1..4).
REQ-002 The module SHALL have these ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- alu_flags  in  4  ALU result flags {N,Z,C,V}
- s_bit  in  1  instruction requests a flag update
- upd_valid  in  1  instruction in the update stage is valid
- cond_pass  in  1  instruction's condition evaluated true
- msr_we  in  1  explicit flag write
- msr_data  in  4  explicit flag value {N,Z,C,V}
- exc_entry  in  1  exception entry; push current flags
- exc_return  in  1  exception return; pop saved flags into SR
- stall  in  1  hold all state
- flush  in  1  discard the current-cycle update
- SR  out  4  committed flags, N=bit3, Z=bit2, C=bit1, V=bit0
- SR_fwd  out  4  flags as seen by the next condition evaluation
- depth  out  3  number of occupied save entries
- flags_changed  out  1  one-cycle pulse when SR changes value
- stack_err  out  1  sticky overflow/underflow error

Function
REQ-003 The ALU update SHALL take effect on the clk edge when upd_valid & s_bit & cond_pass & ~flush & ~stall; SR then equals alu_flags.
REQ-004 The MSR write SHALL take effect on the clk edge when msr_we & ~flush & ~stall; SR then equals msr_data.
REQ-005 Same-cycle priority SHALL be: stall (hold all) > flush (drop ALU/MSR updates) > exc_entry > exc_return > msr_we > ALU update; only one source writes SR per cycle.
REQ-006 Flush SHALL NOT suppress exc_entry or exc_return.
REQ-007 exc_entry with depth < STACK_DEPTH SHALL push SR onto the save stack, increment depth by 1 and leave SR unchanged.
REQ-008 exc_entry with depth == STACK_DEPTH SHALL leave the stack and depth unchanged and set stack_err.
REQ-009 exc_return with depth > 0 SHALL load SR from the top entry and decrement depth by 1.
REQ-010 exc_return with depth == 0 SHALL leave SR and depth unchanged and set stack_err.
REQ-011 Simultaneous exc_entry and exc_return SHALL perform only the entry.
REQ-012 The stack SHALL be LIFO, so the most recently pushed entry is restored first.
REQ-013 flags_changed SHALL be 1 in the cycle after an edge where SR's new value differs from its old value, and 0 otherwise; a write of an identical value SHALL NOT pulse.
REQ-014 stack_err SHALL stay 1 until reset.
REQ-015 A stalled cycle SHALL NOT change any register, including stack_err and flags_changed (flags_changed is held, not cleared).
REQ-016 SR, depth, flags_changed and stack_err SHALL be driven directly from flops.

Reset
REQ-017 While rst_n is 0 the module SHALL asynchronously force SR=4'b0000, all stack entries=0, depth=0, flags_changed=0 and stack_err=0.
REQ-018 Reset asserted mid-sequence (for example with depth=1) SHALL discard all saved entries.
REQ-019 The first update SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-020 With SR_BYPASS_EN defined, SR_fwd SHALL combinationally equal the value SR will take at the next edge, following the REQ-005 priority.
REQ-021 With SR_BYPASS_EN undefined, SR_fwd SHALL equal SR, adding one cycle of flag latency to condition evaluation.
REQ-022 All other behaviour SHALL be identical with and without SR_BYPASS_EN.

Structure
REQ-023 A shared package SHALL hold the flag bit-index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0) and a 4-bit nzcv typedef, shared with condition evaluation and the ALU.
REQ-024 The save stack SHALL be a sub-module named flag_save_stack (push, pop, data in/out, depth, full, empty); priority muxing and SR stay in the top module.

Verification
REQ-025 Reset then upd_valid=s_bit=cond_pass=1, alu_flags=4'b0100 -> SR=4'b0100 after one edge; flags_changed=1 for one cycle.
REQ-026 Same setup with cond_pass=0, or s_bit=0, or flush=1 -> SR unchanged and flags_changed=0.
REQ-027 SR=4'b1001, exc_entry; msr_we with msr_data=4'b0010; exc_return -> SR goes to 4'b0010, then back to 4'b1001; depth goes 1 then 0.
REQ-028 STACK_DEPTH=2, three exc_entry pulses -> depth=2 and stack_err=1; two exc_return pulses restore in LIFO order; a third exc_return leaves SR unchanged.
REQ-029 stall=1 with msr_we and exc_entry asserted -> no change to SR, depth or flags_changed.
REQ-030 With SR_BYPASS_EN, alu update 4'b1000 -> SR_fwd=4'b1000 in the same cycle while SR is still old; without the macro, SR_fwd changes one cycle later.
REQ-031 With depth=1, rst_n pulsed low between clk edges -> SR=0 and depth=0 immediately.
